alu_vector_recorder: RTL and testbench

ALU_VECTOR_RECORDER -- requirements
Module: alu_vector_recorder

---
 rtl/alu_vector_recorder_if.sv | 25 ++
 rtl/alu_vector_recorder.sv | 68 ++++++
 tb/tb_alu_vector_recorder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/alu_vector_recorder_if.sv
// alu_vector_recorder_if: session control, ALU capture and record stream signals
interface alu_vector_recorder_if #(parameter int WIDTH = 32);
  logic                 start;
  logic [15:0]          num_samples;
  logic                 cap_valid;
  logic [WIDTH-1:0]     cap_a;
  logic [WIDTH-1:0]     cap_b;
  logic [1:0]           cap_ctrl;
  logic [WIDTH-1:0]     cap_result;
  logic [3:0]           cap_flags;
  logic                 vec_valid;
  logic                 vec_ready;
  logic [3*WIDTH+7:0]   vec_data;
  logic                 busy;
  logic                 done;
  logic [15:0]          dropped;
  modport master (
    output start, num_samples, cap_valid, cap_a, cap_b, cap_ctrl, cap_result, cap_flags, vec_ready,
    input  vec_valid, vec_data, busy, done, dropped
  );
  modport slave (
    input  start, num_samples, cap_valid, cap_a, cap_b, cap_ctrl, cap_result, cap_flags, vec_ready,
    output vec_valid, vec_data, busy, done, dropped
  );
endinterface

// File: rtl/alu_vector_recorder.sv
// alu_vector_recorder: records a fixed number of ALU transactions into a FIFO
// and streams them out over a valid/ready port.
module alu_vector_recorder #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input logic clk,
  input logic rst_n,
  alu_vector_recorder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = 3*WIDTH+8;
  typedef enum logic [1:0] {IDLE, RECORD, DRAIN} state_t;
  state_t          state;
  logic [AW:0]     wptr, rptr;
  logic [15:0]     remaining, dropped_q;
  logic            done_q;
  logic [RW-1:0]   mem [DEPTH];
  logic            empty, full, rd, cap, wr, drop;
  assign empty = wptr == rptr;
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd    = !empty && bus.vec_ready;
  assign cap   = (state == RECORD) && bus.cap_valid;
  // a read in the same cycle frees the slot, so a full buffer still accepts
  assign wr    = cap && (!full || rd);
  assign drop  = cap && full && !rd;
  assign bus.vec_valid = !empty;
  assign bus.vec_data  = empty ? '0 : mem[rptr[AW-1:0]];
  assign bus.busy      = state != IDLE;
  assign bus.done      = done_q;
  assign bus.dropped   = dropped_q;
  always_ff @(posedge clk)
    if (wr) mem[wptr[AW-1:0]] <= {2'b00, bus.cap_a, bus.cap_b, bus.cap_ctrl, bus.cap_result, bus.cap_flags};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wptr      <= '0;
      rptr      <= '0;
      remaining <= '0;
      dropped_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (rd) rptr <= rptr + (AW+1)'(1);
      if (wr) wptr <= wptr + (AW+1)'(1);
      case (state)
        IDLE:
          if (bus.start) begin
            remaining <= bus.num_samples;
            dropped_q <= '0;
            state     <= (bus.num_samples == 16'd0) ? DRAIN : RECORD;
          end
        RECORD:
          if (bus.cap_valid) begin
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) state <= DRAIN;
            if (drop && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
          end
        DRAIN:
          if (empty) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_vector_recorder.sv
// tb_alu_vector_recorder: directed checks of recording, overflow, handshake and reset
module tb_alu_vector_recorder;
  localparam int W  = 32;
  localparam int D  = 16;
  localparam int RW = 3*W+8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  alu_vector_recorder_if #(.WIDTH(W)) bus ();
  alu_vector_recorder #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int passed = 0;
  int done_cnt = 0;
  logic [RW-1:0] got_q [$];
  always @(negedge clk)
    if (rst_n) begin
      if (bus.vec_valid && bus.vec_ready) got_q.push_back(bus.vec_data);
      if (bus.done) done_cnt++;
    end
  function automatic logic [RW-1:0] rec(input int i);
    return {2'b00, 32'(i*3+1), ~32'(i), 2'(i), 32'(i) << 4, 4'(i)};
  endfunction
  task automatic drive(input int i);
    bus.cap_a      = 32'(i*3+1);
    bus.cap_b      = ~32'(i);
    bus.cap_ctrl   = 2'(i);
    bus.cap_result = 32'(i) << 4;
    bus.cap_flags  = 4'(i);
  endtask
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy && n < 200) begin
      cycle();
      n++;
    end
    chk(tag, 128'(bus.busy), 128'(0));
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n0, d0;
    logic [RW-1:0] big;
    bus.start = 0; bus.num_samples = 0; bus.cap_valid = 0; bus.vec_ready = 0;
    drive(0);
    repeat (2) cycle();
    chk("rst_vec_valid", 128'(bus.vec_valid), 128'(0));
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_done", 128'(bus.done), 128'(0));
    chk("rst_dropped", 128'(bus.dropped), 128'(0));
    chk("rst_vec_data", 128'(bus.vec_data), 128'(0));
    bus.cap_valid = 1;
    rst_n = 1;
    cycle();
    chk("release_busy", 128'(bus.busy), 128'(0));
    chk("release_no_capture", 128'(bus.vec_valid), 128'(0));
    bus.cap_valid = 0;
    // three records streamed straight through
    n0 = got_q.size(); d0 = done_cnt;
    bus.start = 1; bus.num_samples = 3;
    cycle();
    bus.start = 0;
    chk("s1_busy", 128'(bus.busy), 128'(1));
    bus.vec_ready = 1;
    for (int i = 0; i < 3; i++) begin
      drive(i); bus.cap_valid = 1;
      cycle();
      if (i == 0) chk("s1_latency", 128'(bus.vec_valid), 128'(1));
    end
    bus.cap_valid = 0;
    wait_idle("s1_idle");
    cycle();
    chk("s1_count", 128'(got_q.size() - n0), 128'(3));
    for (int k = 0; k < 3; k++) chk($sformatf("s1_rec%0d", k), 128'(got_q[n0+k]), 128'(rec(k)));
    chk("s1_done", 128'(done_cnt - d0), 128'(1));
    chk("s1_dropped", 128'(bus.dropped), 128'(0));
    // overflow, then a write into a full buffer with a simultaneous read
    n0 = got_q.size(); d0 = done_cnt;
    bus.vec_ready = 0;
    bus.start = 1; bus.num_samples = 21;
    cycle();
    bus.start = 0;
    for (int i = 0; i < 20; i++) begin
      drive(i); bus.cap_valid = 1;
      cycle();
    end
    chk("s2_dropped4", 128'(bus.dropped), 128'(4));
    chk("s2_valid", 128'(bus.vec_valid), 128'(1));
    chk("s2_busy", 128'(bus.busy), 128'(1));
    drive(20); bus.vec_ready = 1;
    cycle();
    bus.cap_valid = 0;
    chk("s2_full_rw_dropped", 128'(bus.dropped), 128'(4));
    chk("s2_drain", 128'(bus.busy), 128'(1));
    wait_idle("s2_idle");
    cycle();
    chk("s2_count", 128'(got_q.size() - n0), 128'(17));
    chk("s2_first", 128'(got_q[n0]), 128'(rec(0)));
    chk("s2_rec15", 128'(got_q[n0+15]), 128'(rec(15)));
    chk("s2_rec20", 128'(got_q[n0+16]), 128'(rec(20)));
    chk("s2_done", 128'(done_cnt - d0), 128'(1));
    // packing of a corner-case record, stability under backpressure
    bus.vec_ready = 0;
    bus.start = 1; bus.num_samples = 1;
    cycle();
    bus.start = 0;
    chk("s3_dropped_clear", 128'(bus.dropped), 128'(0));
    bus.cap_a = 32'h7FFFFFFF; bus.cap_b = 32'h1; bus.cap_ctrl = 2'b00;
    bus.cap_result = 32'h80000000; bus.cap_flags = 4'b1001; bus.cap_valid = 1;
    big = {2'b00, 32'h7FFFFFFF, 32'h00000001, 2'b00, 32'h80000000, 4'b1001};
    cycle();
    bus.cap_valid = 0;
    chk("s3_pack", 128'(bus.vec_data), 128'(big));
    bus.start = 1; bus.num_samples = 5;
    cycle();
    bus.start = 0;
    chk("s3_stable", 128'(bus.vec_data), 128'(big));
    chk("s3_hold_valid", 128'(bus.vec_valid), 128'(1));
    bus.vec_ready = 1;
    wait_idle("s3_idle_start_ignored");
    cycle();
    // reset in the middle of a session
    bus.vec_ready = 0;
    bus.start = 1; bus.num_samples = 10;
    cycle();
    bus.start = 0;
    for (int i = 0; i < 5; i++) begin
      drive(i); bus.cap_valid = 1;
      cycle();
    end
    bus.cap_valid = 0;
    chk("s4_buffered", 128'(bus.vec_valid), 128'(1));
    d0 = done_cnt;
    rst_n = 0;
    #1;
    chk("s4_async_valid", 128'(bus.vec_valid), 128'(0));
    chk("s4_async_busy", 128'(bus.busy), 128'(0));
    chk("s4_async_data", 128'(bus.vec_data), 128'(0));
    cycle();
    cycle();
    bus.cap_valid = 1;
    rst_n = 1;
    cycle();
    bus.cap_valid = 0;
    chk("s4_idle", 128'(bus.busy), 128'(0));
    chk("s4_discarded", 128'(bus.vec_valid), 128'(0));
    cycle();
    chk("s4_no_done", 128'(done_cnt - d0), 128'(0));
    // empty session
    d0 = done_cnt;
    bus.start = 1; bus.num_samples = 0;
    cycle();
    bus.start = 0;
    chk("s5_drain", 128'(bus.busy), 128'(1));
    chk("s5_no_valid", 128'(bus.vec_valid), 128'(0));
    cycle();
    chk("s5_done", 128'(bus.done), 128'(1));
    chk("s5_idle", 128'(bus.busy), 128'(0));
    cycle();
    chk("s5_done_pulse", 128'(bus.done), 128'(0));
    chk("s5_done_once", 128'(done_cnt - d0), 128'(1));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
